mem_arbiter: RTL and testbench

Arbitrates the single shared main-memory port between the instruction-cache miss path (read-only) and the data-cache miss/writeback path (read/write) in the 16-bit pipelined processor. One transaction is in flight at a time. The D side has priority, with a starvation guard that guarantees I-side progress. A watchdog detects a hung memory.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter between the I-cache miss path and the D-cache
// miss/writeback path: D priority with a streak limit, one transaction in flight.
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 3,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data_out,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  output logic [15:0] d_data_out,
  output logic        d_done,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_data_out,
  output logic        busy,
  output logic        owner,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] i_data_q, i_data_d;
  logic [15:0] d_data_q, d_data_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        grant_d;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    i_data_d = i_data_q;
    d_data_d = d_data_q;
    streak_d = streak_q;
    tcnt_d   = tcnt_q;
    grant_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // D wins unless I is also waiting and D has used up its streak
          grant_d = d_req && (!i_req || (streak_q < STREAK_MAX));
          owner_d = grant_d;
          addr_d  = grant_d ? d_addr : i_addr;
          wr_d    = grant_d && d_wr;
          wdata_d = grant_d ? d_data_in : '0;
          if (grant_d && i_req)
            streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
          else
            streak_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_stall) begin
          tcnt_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        tcnt_d = tcnt_q + 8'd1;
        if (mem_done) begin
          if (!owner_q)    i_data_d = mem_data_out;
          else if (!wr_q)  d_data_d = mem_data_out;
          state_d = RESP;
        end else if (tcnt_q == TCNT_LAST) begin
          err_d = 1'b1;
          if (!owner_q) i_data_d = '0;
          else          d_data_d = '0;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_data_q <= '0;
      d_data_q <= '0;
      streak_q <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
      streak_q <= streak_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;
  assign err         = err_q;
  assign mem_rd      = (state_q == ISSUE) && !wr_q;
  assign mem_wr      = (state_q == ISSUE) && wr_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign i_done      = (state_q == RESP) && !owner_q;
  assign d_done      = (state_q == RESP) && owner_q;
  assign i_data_out  = i_data_q;
  assign d_data_out  = d_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: behavioural memory responder plus a done-pulse
// scoreboard fed by the scenario tasks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_data_in = '0;
  logic [15:0] i_data_out, d_data_out, mem_addr, mem_data_in;
  logic        i_done, d_done, mem_rd, mem_wr, busy, owner, err;
  logic        mem_stall = 1'b0, mem_done = 1'b0;
  logic [15:0] mem_data_out = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_D_STREAK(3), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data_out(i_data_out), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
    .d_data_out(d_data_out), .d_done(d_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_data_out(mem_data_out),
    .busy(busy), .owner(owner), .err(err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic side; logic [15:0] data; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] exp_d_last = '0;

  logic [15:0] mem_arr [logic [15:0]];

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : (a ^ 16'h5A5A);
  endfunction

  // Memory responder: stalls a fresh strobe cfg_stall cycles, answers 1 cycle after accept
  int          cfg_stall = 0;
  bit          cfg_never = 1'b0;
  int          stall_left = 0;
  bit          strobe_seen = 1'b0;
  int          pend = 0;
  logic [15:0] pend_data = '0;

  always @(posedge clk) begin
    #1;
    mem_done     = 1'b0;
    mem_data_out = 16'hDEAD;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_done     = 1'b1;
        mem_data_out = pend_data;
      end
    end
    if (mem_rd || mem_wr) begin
      if (!strobe_seen) begin
        strobe_seen = 1'b1;
        stall_left  = cfg_stall;
      end
      if (stall_left > 0) begin
        mem_stall = 1'b1;
        stall_left--;
      end else begin
        mem_stall   = 1'b0;
        strobe_seen = 1'b0;
        if (mem_wr) mem_arr[mem_addr] = mem_data_in;
        else        pend_data = mem_model(mem_addr);
        if (!cfg_never) pend = 1;
      end
    end else begin
      mem_stall = 1'b0;
    end
  end

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(posedge clk) begin
    #1;
    if (i_done || d_done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: i_done=%0b d_done=%0b, required none", i_done, d_done);
      end else begin
        mon_e = sb.pop_front();
        if ({i_done, d_done, owner} !== (mon_e.side ? 3'b011 : 3'b100)) begin
          bad++;
          $display("FAIL done_side: {i_done,d_done,owner}=%b, required side=%0b", {i_done, d_done, owner}, mon_e.side);
        end
        total++;
        if ((mon_e.side ? d_data_out : i_data_out) !== mon_e.data) begin
          bad++;
          $display("FAIL done_data: got %h, required %h (side=%0b)",
                   mon_e.side ? d_data_out : i_data_out, mon_e.data, mon_e.side);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic side, input logic [15:0] data);
    exp_t e;
    e.side = side;
    e.data = data;
    sb.push_back(e);
    if (side) exp_d_last = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, owner, err, i_done, d_done, mem_rd, mem_wr} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: {busy,owner,err,i_done,d_done,rd,wr}=%b, required 0", {busy, owner, err, i_done, d_done, mem_rd, mem_wr});
    end
    total++;
    if ({mem_addr, mem_data_in, i_data_out, d_data_out} !== 64'h0) begin
      bad++;
      $display("FAIL reset_data: %h %h %h %h, required all 0", mem_addr, mem_data_in, i_data_out, d_data_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_i_read();
    mem_arr[16'h0040] = 16'hBEEF;
    i_addr = 16'h0040;
    i_req  = 1'b1;
    push_exp(1'b0, 16'hBEEF);
    tick();
    total++;
    if ({mem_rd, mem_wr, busy, owner, mem_addr} !== {4'b1010, 16'h0040}) begin
      bad++;
      $display("FAIL i_read_issue: {rd,wr,busy,owner}=%b addr=%h, required 1010 0040", {mem_rd, mem_wr, busy, owner}, mem_addr);
    end
    tick();
    total++;
    if ({mem_rd, busy, i_done} !== 3'b010) begin
      bad++;
      $display("FAIL i_read_wait: {rd,busy,i_done}=%b, required 010", {mem_rd, busy, i_done});
    end
    tick();
    total++;
    if ({i_done, d_done, i_data_out} !== {2'b10, 16'hBEEF}) begin
      bad++;
      $display("FAIL i_read_done: i_done=%0b d_done=%0b data=%h, required 1 0 beef", i_done, d_done, i_data_out);
    end
    i_req = 1'b0;
    tick();
    total++;
    if ({busy, i_done} !== 2'b00) begin
      bad++;
      $display("FAIL i_read_idle: {busy,i_done}=%b, required 00", {busy, i_done});
    end
  endtask

  task automatic test_d_write_stall();
    cfg_stall = 3;
    d_wr      = 1'b1;
    d_addr    = 16'h1000;
    d_data_in = 16'h1234;
    d_req     = 1'b1;
    push_exp(1'b1, exp_d_last);
    for (int k = 1; k <= 4; k++) begin
      tick();
      d_data_in = 16'hFFFF;
      total++;
      if ({mem_wr, mem_rd, mem_addr, mem_data_in} !== {2'b10, 16'h1000, 16'h1234}) begin
        bad++;
        $display("FAIL d_write_issue[%0d]: {wr,rd}=%b addr=%h wdata=%h, required 10 1000 1234", k, {mem_wr, mem_rd}, mem_addr, mem_data_in);
      end
    end
    tick();
    total++;
    if ({mem_wr, busy, d_done} !== 3'b010) begin
      bad++;
      $display("FAIL d_write_wait: {wr,busy,d_done}=%b, required 010", {mem_wr, busy, d_done});
    end
    tick();
    total++;
    if ({d_done, i_done, d_data_out} !== {2'b10, 16'h0000}) begin
      bad++;
      $display("FAIL d_write_done: d_done=%0b i_done=%0b d_data_out=%h, required 1 0 0000", d_done, i_done, d_data_out);
    end
    d_req     = 1'b0;
    d_wr      = 1'b0;
    cfg_stall = 0;
    tick();
  endtask

  task automatic test_streak();
    int unsigned streak = 0;
    int n = 0;
    logic [7:0] exp_order = '0;
    logic [7:0] obs_order = '0;
    i_addr = 16'h0100;
    d_addr = 16'h0200;
    d_wr   = 1'b0;
    for (int unsigned g = 0; g < 8; g++) begin
      if (streak < 3) begin
        exp_order[g] = 1'b1;
        streak++;
        push_exp(1'b1, mem_model(16'h0200));
      end else begin
        streak = 0;
        push_exp(1'b0, mem_model(16'h0100));
      end
    end
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 0; c < 100 && n < 8; c++) begin
      tick();
      if (i_done || d_done) begin
        obs_order[n] = d_done;
        n++;
        if (n == 8) begin
          i_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL streak_count: done pulses=%0d, required 8", n);
      i_req = 1'b0;
      d_req = 1'b0;
    end
    total++;
    if (obs_order !== exp_order) begin
      bad++;
      $display("FAIL streak_order: grants(bit0 first, 1=D)=%b, required %b", obs_order, exp_order);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    cfg_stall = 1;
    i_addr = 16'h0100;
    d_addr = 16'h0200;
    i_req  = 1'b1;
    d_req  = 1'b1;
    push_exp(1'b1, mem_model(16'h0200));
    tick();
    total++;
    if ({owner, mem_rd, mem_addr} !== {2'b11, 16'h0200}) begin
      bad++;
      $display("FAIL simul_grant: owner=%0b rd=%0b addr=%h, required 1 1 0200", owner, mem_rd, mem_addr);
    end
    d_addr = 16'h0300;
    i_addr = 16'h0999;
    i_req  = 1'b0;
    tick();
    total++;
    if ({owner, mem_addr} !== {1'b1, 16'h0200}) begin
      bad++;
      $display("FAIL simul_latched: owner=%0b addr=%h, required 1 0200", owner, mem_addr);
    end
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    tick();
    total++;
    if ({d_done, i_done, owner} !== 3'b101) begin
      bad++;
      $display("FAIL simul_done: {d_done,i_done,owner}=%b, required 101", {d_done, i_done, owner});
    end
    d_req     = 1'b0;
    cfg_stall = 0;
    tick();
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL simul_idle: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_timeout();
    bit got = 1'b0;
    cfg_never = 1'b1;
    d_addr = 16'h0200;
    d_wr   = 1'b0;
    d_req  = 1'b1;
    push_exp(1'b1, 16'h0000);
    for (int k = 1; k <= 66; k++) begin
      tick();
      if (k == 65) begin
        total++;
        if ({err, busy, d_done} !== 3'b010) begin
          bad++;
          $display("FAIL timeout_last_wait: {err,busy,d_done}=%b, required 010", {err, busy, d_done});
        end
      end
      if (k == 66) begin
        total++;
        if ({d_done, err, d_data_out} !== {2'b11, 16'h0000}) begin
          bad++;
          $display("FAIL timeout_resp: d_done=%0b err=%0b data=%h, required 1 1 0000", d_done, err, d_data_out);
        end
        d_req = 1'b0;
      end
    end
    cfg_never = 1'b0;
    tick();
    i_addr = 16'h0040;
    i_req  = 1'b1;
    push_exp(1'b0, 16'hBEEF);
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (i_done) begin
        got   = 1'b1;
        i_req = 1'b0;
      end
    end
    i_req = 1'b0;
    total++;
    if ({got, err} !== 2'b11) begin
      bad++;
      $display("FAIL timeout_recover: done_seen=%0b err=%0b, required 1 1", got, err);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    int n = 0;
    logic [1:0] obs = '0;
    i_addr = 16'h0100;
    d_addr = 16'h0200;
    d_wr   = 1'b0;
    push_exp(1'b1, mem_model(16'h0200));
    push_exp(1'b1, mem_model(16'h0200));
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 0; c < 40 && n < 2; c++) begin
      tick();
      if (i_done || d_done) n++;
    end
    tick();
    tick();
    total++;
    if ({mem_rd, owner, busy} !== 3'b111) begin
      bad++;
      $display("FAIL rst_wait_issue: {rd,owner,busy}=%b, required 111", {mem_rd, owner, busy});
    end
    tick();
    rst   = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    exp_d_last = '0;
    total++;
    if ({busy, i_done, d_done, err, owner, mem_rd, mem_wr, i_data_out, d_data_out} !== 39'h0) begin
      bad++;
      $display("FAIL rst_wait_state: {busy,i_done,d_done,err,owner,rd,wr}=%b i_data=%h d_data=%h, required all 0",
               {busy, i_done, d_done, err, owner, mem_rd, mem_wr}, i_data_out, d_data_out);
    end
    tick();
    tick();
    push_exp(1'b1, mem_model(16'h0200));
    push_exp(1'b0, mem_model(16'h0100));
    i_req = 1'b1;
    d_req = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      tick();
      if (i_done || d_done) begin
        obs[n] = d_done;
        n++;
        d_req = 1'b0;
        if (n == 2) i_req = 1'b0;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    total++;
    if ({n[1:0], obs} !== 4'b1001) begin
      bad++;
      $display("FAIL rst_wait_after: dones=%0d order(bit0 first,1=D)=%b, required 2 01", n, obs);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write_stall();
    test_streak();
    test_simultaneous();
    test_timeout();
    test_reset_in_wait();
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations: %0d outstanding, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
